// File: rtl/bus_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : bus_arbiter (with tilelink_pkg)
//  Description : Two-requester, one-target round-robin arbiter for the
//                pinwheel data bus. One outstanding transaction, combinational
//                request issue and response steering, plus a watchdog that
//                answers with an error response when a target never replies.
//  Revision    : 1.0 - initial release
// ============================================================================

package tilelink_pkg;

    // TileLink channel A opcodes used by this bus
    localparam logic [2:0] c_op_put_partial = 3'd1;
    localparam logic [2:0] c_op_get         = 3'd4;

    typedef struct packed {
        logic        a_valid;
        logic [2:0]  a_opcode;
        logic [2:0]  a_param;
        logic [2:0]  a_size;
        logic        a_source;
        logic [31:0] a_address;
        logic [3:0]  a_mask;
        logic [31:0] a_data;
    } tilelink_a;

endpackage

module bus_arbiter
    import tilelink_pkg::*;
#(
    parameter int unsigned TIMEOUT  = 16,
    parameter logic [31:0] ERR_DATA = 32'hDEADBEEF
) (
    input  logic        clock,
    input  logic        reset_in,

    input  logic        req0_valid,
    input  logic        req0_wren,
    input  logic [31:0] req0_addr,
    input  logic [31:0] req0_wdata,
    input  logic [3:0]  req0_wmask,
    output logic        req0_ready,

    input  logic        req1_valid,
    input  logic        req1_wren,
    input  logic [31:0] req1_addr,
    input  logic [31:0] req1_wdata,
    input  logic [3:0]  req1_wmask,
    output logic        req1_ready,

    output logic        rsp0_valid,
    output logic        rsp1_valid,
    output logic [31:0] rsp_data,
    output logic        rsp_err,

    output tilelink_a   bus_tla,
    input  logic        bus_d_valid,
    input  logic [31:0] bus_d_data,

    output logic        busy
);

    typedef enum logic [0:0] {
        S_IDLE = 1'b0,
        S_BUSY = 1'b1
    } state_t;

    // Timer comparison value; TIMEOUT is limited to 2..255 so it fits 8 bits
    localparam logic [7:0] c_timer_last = 8'(TIMEOUT - 1);

    state_t      r_state;
    logic        r_last_grant;
    logic        r_owner;
    logic [7:0]  r_timer;

    logic        w_busy;
    logic        w_timeout;
    logic        w_done;
    logic        w_can_accept;
    logic        w_accept;
    logic        w_grant;
    logic        w_rsp;

    assign w_busy = (r_state == S_BUSY);

    // Watchdog fires on the last allowed silent cycle; a real ack wins over it
    assign w_timeout = w_busy && !bus_d_valid && (r_timer == c_timer_last);

    // Completion this cycle; suppressed while reset is held so a dropped
    // transaction never produces a response
    assign w_done = !reset_in && w_busy && (bus_d_valid || w_timeout);

    // A completing transaction frees the bus in the same cycle, allowing
    // back-to-back issue against single-cycle targets
    assign w_can_accept = !reset_in && ((r_state == S_IDLE) || w_done);
    assign w_accept     = w_can_accept && (req0_valid || req1_valid);

    // Round-robin pick: a lone requester wins, contention goes to the one
    // that was not served last
    always_comb begin
        w_grant = 1'b0;
        if (req0_valid && req1_valid) begin
            w_grant = ~r_last_grant;
        end else if (req1_valid) begin
            w_grant = 1'b1;
        end
    end

    assign req0_ready = w_accept && (w_grant == 1'b0);
    assign req1_ready = w_accept && (w_grant == 1'b1);

    // Drive channel A from the granted requester only in the acceptance cycle
    always_comb begin
        bus_tla = '0;
        if (w_accept) begin
            bus_tla.a_valid = 1'b1;
            bus_tla.a_size  = 3'd2;
            if (w_grant) begin
                bus_tla.a_opcode  = req1_wren ? c_op_put_partial : c_op_get;
                bus_tla.a_address = req1_addr;
                bus_tla.a_mask    = req1_wmask;
                bus_tla.a_data    = req1_wdata;
            end else begin
                bus_tla.a_opcode  = req0_wren ? c_op_put_partial : c_op_get;
                bus_tla.a_address = req0_addr;
                bus_tla.a_mask    = req0_wmask;
                bus_tla.a_data    = req0_wdata;
            end
        end
    end

    // Response steering to the owner; data bus is zero when no response
    assign w_rsp      = w_done;
    assign rsp0_valid = w_rsp && (r_owner == 1'b0);
    assign rsp1_valid = w_rsp && (r_owner == 1'b1);
    assign rsp_err    = w_rsp && !bus_d_valid;
    assign rsp_data   = !w_rsp     ? 32'h0 :
                        bus_d_valid ? bus_d_data : ERR_DATA;

    assign busy = w_busy;

    // Transaction FSM: ownership, fairness pointer and watchdog timer
    always_ff @(posedge clock) begin
        if (reset_in) begin
            r_state      <= S_IDLE;
            r_last_grant <= 1'b1;
            r_owner      <= 1'b0;
            r_timer      <= 8'd0;
        end else if (w_accept) begin
            r_state      <= S_BUSY;
            r_owner      <= w_grant;
            r_last_grant <= w_grant;
            r_timer      <= 8'd0;
        end else if (w_done) begin
            r_state      <= S_IDLE;
            r_timer      <= 8'd0;
        end else if (w_busy && (r_timer != 8'hFF)) begin
            r_timer      <= r_timer + 8'd1;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_bus_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : tb_bus_arbiter
//  Description : Directed testbench for bus_arbiter. Expected responses are
//                queued when transactions are issued and checked by an
//                independent response monitor.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_bus_arbiter;
    import tilelink_pkg::*;

    logic        clock = 1'b0;
    logic        reset_in = 1'b1;
    logic        req0_valid = 1'b0, req0_wren = 1'b0;
    logic [31:0] req0_addr = '0, req0_wdata = '0;
    logic [3:0]  req0_wmask = '0;
    logic        req0_ready;
    logic        req1_valid = 1'b0, req1_wren = 1'b0;
    logic [31:0] req1_addr = '0, req1_wdata = '0;
    logic [3:0]  req1_wmask = '0;
    logic        req1_ready;
    logic        rsp0_valid, rsp1_valid, rsp_err, busy;
    logic [31:0] rsp_data;
    tilelink_a   bus_tla;
    logic        bus_d_valid = 1'b0;
    logic [31:0] bus_d_data = '0;

    typedef struct {
        logic        which;
        logic [31:0] data;
        logic        err;
    } exp_t;

    exp_t exp_q[$];
    int   n_checks = 0;
    int   n_errors = 0;

    bus_arbiter #(.TIMEOUT(16), .ERR_DATA(32'hDEADBEEF)) dut (
        .clock(clock), .reset_in(reset_in),
        .req0_valid(req0_valid), .req0_wren(req0_wren), .req0_addr(req0_addr),
        .req0_wdata(req0_wdata), .req0_wmask(req0_wmask), .req0_ready(req0_ready),
        .req1_valid(req1_valid), .req1_wren(req1_wren), .req1_addr(req1_addr),
        .req1_wdata(req1_wdata), .req1_wmask(req1_wmask), .req1_ready(req1_ready),
        .rsp0_valid(rsp0_valid), .rsp1_valid(rsp1_valid), .rsp_data(rsp_data),
        .rsp_err(rsp_err), .bus_tla(bus_tla), .bus_d_valid(bus_d_valid),
        .bus_d_data(bus_d_data), .busy(busy)
    );

    always #5 clock = ~clock;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_checks++;
        if (act !== req) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, req, $time);
        end
    endtask

    task automatic next_cycle();
        @(posedge clock);
        #1;
    endtask

    task automatic push_exp(input logic which, input logic [31:0] data, input logic err);
        exp_t e;
        e.which = which;
        e.data  = data;
        e.err   = err;
        exp_q.push_back(e);
    endtask

    // Response monitor: every presented response must match the queue head
    always @(negedge clock) begin
        exp_t e;
        if (!reset_in) begin
            check("rsp_exclusive", 32'(rsp0_valid & rsp1_valid), 32'd0);
            if (rsp0_valid || rsp1_valid) begin
                if (exp_q.size() == 0) begin
                    check("rsp_unexpected", 32'(rsp1_valid), 32'hFFFF_FFFF);
                end else begin
                    e = exp_q.pop_front();
                    check("rsp_owner", 32'(rsp1_valid), 32'(e.which));
                    check("rsp_data", rsp_data, e.data);
                    check("rsp_err", 32'(rsp_err), 32'(e.err));
                end
            end else begin
                check("rsp_data_idle", rsp_data, 32'd0);
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        // ---------------- reset ----------------
        next_cycle();
        next_cycle();
        @(negedge clock);
        check("reset_busy", 32'(busy), 32'd0);
        check("reset_a_valid", 32'(bus_tla.a_valid), 32'd0);
        check("reset_rsp", 32'({rsp0_valid, rsp1_valid, rsp_err}), 32'd0);
        check("reset_ready", 32'({req0_ready, req1_ready}), 32'd0);

        // ---------------- T1: single Get from requester 0 ----------------
        next_cycle();
        reset_in = 1'b0;
        req0_valid = 1'b1; req0_wren = 1'b0; req0_addr = 32'h8000_0010;
        push_exp(1'b0, 32'h1234_5678, 1'b0);
        @(negedge clock);
        check("t1_ready0", 32'(req0_ready), 32'd1);
        check("t1_ready1", 32'(req1_ready), 32'd0);
        check("t1_a_valid", 32'(bus_tla.a_valid), 32'd1);
        check("t1_a_address", bus_tla.a_address, 32'h8000_0010);
        check("t1_a_opcode", 32'(bus_tla.a_opcode), 32'd4);
        check("t1_a_size", 32'(bus_tla.a_size), 32'd2);
        next_cycle();
        req0_valid = 1'b0;
        bus_d_valid = 1'b1; bus_d_data = 32'h1234_5678;
        @(negedge clock);
        check("t1_busy", 32'(busy), 32'd1);
        check("t1_rsp0", 32'(rsp0_valid), 32'd1);
        next_cycle();
        bus_d_valid = 1'b0;
        @(negedge clock);
        check("t1_idle", 32'(busy), 32'd0);

        // ---------------- T3: requester 1 Put, requester 0 blocked ----------------
        next_cycle();
        req1_valid = 1'b1; req1_wren = 1'b1; req1_addr = 32'hF000_0000;
        req1_wdata = 32'hCAFE_F00D; req1_wmask = 4'b1111;
        req0_valid = 1'b1; req0_wren = 1'b0; req0_addr = 32'h8000_0020;
        push_exp(1'b1, 32'h0000_0001, 1'b0);
        @(negedge clock);
        check("t3_ready1", 32'(req1_ready), 32'd1);
        check("t3_ready0", 32'(req0_ready), 32'd0);
        check("t3_a_opcode", 32'(bus_tla.a_opcode), 32'd1);
        check("t3_a_mask", 32'(bus_tla.a_mask), 32'hF);
        check("t3_a_data", bus_tla.a_data, 32'hCAFE_F00D);
        check("t3_a_address", bus_tla.a_address, 32'hF000_0000);
        next_cycle();
        req1_valid = 1'b0; req1_wren = 1'b0;
        @(negedge clock);
        check("t3_blocked0", 32'(req0_ready), 32'd0);
        check("t3_no_issue", 32'(bus_tla.a_valid), 32'd0);
        next_cycle();
        bus_d_valid = 1'b1; bus_d_data = 32'h0000_0001;
        push_exp(1'b0, 32'h55AA_55AA, 1'b0);
        @(negedge clock);
        check("t3_rsp1", 32'(rsp1_valid), 32'd1);
        check("t3_ready0_on_ack", 32'(req0_ready), 32'd1);
        check("t3_a_address0", bus_tla.a_address, 32'h8000_0020);
        next_cycle();
        req0_valid = 1'b0;
        bus_d_data = 32'h55AA_55AA;
        @(negedge clock);
        check("t3_rsp0", 32'(rsp0_valid), 32'd1);
        next_cycle();
        bus_d_valid = 1'b0;
        @(negedge clock);
        check("t3_idle", 32'(busy), 32'd0);

        // ---------------- T6: ack while idle is ignored ----------------
        next_cycle();
        bus_d_valid = 1'b1; bus_d_data = 32'h0000_0077;
        @(negedge clock);
        check("t6_rsp", 32'({rsp0_valid, rsp1_valid}), 32'd0);
        check("t6_busy", 32'(busy), 32'd0);
        next_cycle();
        bus_d_valid = 1'b0;
        @(negedge clock);
        check("t6_busy_after", 32'(busy), 32'd0);

        // ---------------- T4: watchdog timeout with pending requester 1 ----------------
        next_cycle();
        req0_valid = 1'b1; req0_wren = 1'b0; req0_addr = 32'h9000_0000;
        push_exp(1'b0, 32'hDEAD_BEEF, 1'b1);
        @(negedge clock);
        check("t4_ready0", 32'(req0_ready), 32'd1);
        for (int c = 1; c <= 16; c++) begin
            next_cycle();
            req0_valid = 1'b0;
            if (c == 10) begin
                req1_valid = 1'b1; req1_wren = 1'b0; req1_addr = 32'hA000_0000;
            end
            @(negedge clock);
            if (c < 16) begin
                check("t4_no_rsp_early", 32'(rsp0_valid), 32'd0);
                check("t4_busy", 32'(busy), 32'd1);
                if (c >= 10) check("t4_ready1_wait", 32'(req1_ready), 32'd0);
            end else begin
                check("t4_rsp0_timeout", 32'(rsp0_valid), 32'd1);
                check("t4_rsp_err", 32'(rsp_err), 32'd1);
                check("t4_ready1_same_cycle", 32'(req1_ready), 32'd1);
                check("t4_a_address1", bus_tla.a_address, 32'hA000_0000);
            end
        end

        // ---------------- T5: reset while busy, late ack ignored ----------------
        next_cycle();
        req1_valid = 1'b0;
        reset_in = 1'b1;
        @(negedge clock);
        check("t5_rsp_in_reset", 32'({rsp0_valid, rsp1_valid}), 32'd0);
        next_cycle();
        reset_in = 1'b0;
        bus_d_valid = 1'b1; bus_d_data = 32'h0000_1111;
        @(negedge clock);
        check("t5_late_ack", 32'({rsp0_valid, rsp1_valid}), 32'd0);
        check("t5_idle", 32'(busy), 32'd0);
        next_cycle();
        bus_d_valid = 1'b0;

        // ---------------- T2: continuous contention, alternating grants ----------------
        for (int i = 0; i < 6; i++) begin
            logic        g;
            logic [31:0] a;
            g = 1'(i % 2);
            a = (g ? 32'h0000_0200 : 32'h0000_0100) + 32'(4 * (i / 2));
            if (i > 0) next_cycle();
            req0_valid = 1'b1; req0_addr = 32'h0000_0100 + 32'(4 * ((i + 1) / 2));
            req1_valid = 1'b1; req1_addr = 32'h0000_0200 + 32'(4 * (i / 2));
            bus_d_valid = (i > 0);
            bus_d_data  = 32'hD000_0000 + 32'(i - 1);
            push_exp(g, 32'hD000_0000 + 32'(i), 1'b0);
            @(negedge clock);
            check("t2_ready0", 32'(req0_ready), 32'(!g));
            check("t2_ready1", 32'(req1_ready), 32'(g));
            check("t2_a_address", bus_tla.a_address, a);
        end
        next_cycle();
        req0_valid = 1'b0; req1_valid = 1'b0;
        bus_d_valid = 1'b1; bus_d_data = 32'hD000_0005;
        @(negedge clock);
        check("t2_last_rsp1", 32'(rsp1_valid), 32'd1);
        next_cycle();
        bus_d_valid = 1'b0;
        @(negedge clock);
        check("t2_idle", 32'(busy), 32'd0);

        next_cycle();
        @(negedge clock);
        check("queue_drained", 32'(exp_q.size()), 32'd0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
